// File: rtl/key_conditioner.sv
// key_conditioner: sync, debounce, edge pulses and auto-repeat
// for the active-low pushbuttons feeding the game logic.
module key_conditioner #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter logic [NUM_KEYS-1:0] REPEAT_MASK = 4'b0011,
  parameter int CNT_W           = 25
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_n_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_repeat,
  output logic                any_press
);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    RPT
  } rpt_e;

  localparam logic [CNT_W-1:0] DB_T = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_T = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_T = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [NUM_KEYS-1:0] s1;
  logic [NUM_KEYS-1:0] s2;
  logic [CNT_W-1:0]    db_cnt [NUM_KEYS];
  logic [CNT_W-1:0]    rp_cnt [NUM_KEYS];
  rpt_e                state  [NUM_KEYS];

  logic [NUM_KEYS-1:0] diff;
  logic [NUM_KEYS-1:0] acc;
  logic [NUM_KEYS-1:0] rise;
  logic [NUM_KEYS-1:0] fall;

  // s2 is active-low, key_level active-high
  always_comb begin
    diff = ~s2 ^ key_level;
    acc  = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      acc[i] = diff[i] && (db_cnt[i] == DB_T);
    end
    rise = acc & ~key_level;
    fall = acc & key_level;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1          <= '1;
      s2          <= '1;
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
      key_repeat  <= '0;
      any_press   <= 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        db_cnt[i] <= '0;
        rp_cnt[i] <= '0;
        state[i]  <= IDLE;
      end
    end else begin
      s1          <= key_n_in;
      s2          <= s1;
      key_level   <= key_level ^ acc;
      key_press   <= rise;
      key_release <= fall;
      any_press   <= |rise;
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (!diff[i] || acc[i]) begin
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + ONE;
        end
        key_repeat[i] <= 1'b0;
        unique case (state[i])
          IDLE: begin
            rp_cnt[i] <= '0;
            if (rise[i]) begin
              key_repeat[i] <= 1'b1;
              state[i]      <= DELAY;
            end
          end
          DELAY: begin
            if (fall[i]) begin
              rp_cnt[i] <= '0;
              state[i]  <= IDLE;
            end else if (rp_cnt[i] == RD_T) begin
              // masked keys park in DELAY without pulsing
              rp_cnt[i] <= '0;
              if (REPEAT_MASK[i]) begin
                key_repeat[i] <= 1'b1;
                state[i]      <= RPT;
              end
            end else begin
              rp_cnt[i] <= rp_cnt[i] + ONE;
            end
          end
          RPT: begin
            if (fall[i]) begin
              rp_cnt[i] <= '0;
              state[i]  <= IDLE;
            end else if (rp_cnt[i] == RP_T) begin
              rp_cnt[i]     <= '0;
              key_repeat[i] <= 1'b1;
            end else begin
              rp_cnt[i] <= rp_cnt[i] + ONE;
            end
          end
          default: begin
            rp_cnt[i] <= '0;
            state[i]  <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed checks of debounce, pulses,
// auto-repeat, release/terminal overlap and async reset.
module tb_key_conditioner;

  logic       clk;
  logic       rst;
  logic [3:0] key_n_in;
  logic [3:0] key_level;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic [3:0] key_repeat;
  logic       any_press;

  int checks;
  int errors;

  key_conditioner #(
    .NUM_KEYS       (4),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3),
    .REPEAT_MASK    (4'b0011),
    .CNT_W          (25)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_n_in   (key_n_in),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_repeat (key_repeat),
    .any_press  (any_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [16:0] outs();
    return {key_level, key_press, key_release, key_repeat, any_press};
  endfunction

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    key_n_in = 4'b0000;
    tick(3);
    chk("rst_outs", 32'(outs()), 32'h0);

    // all keys held through reset release
    rst = 1'b1;
    tick(5);
    chk("rst_lvl_e5", 32'(key_level), 32'h0);
    tick(1);
    chk("rst_lvl", 32'(key_level), 32'hf);
    chk("rst_press", 32'(key_press), 32'hf);
    chk("rst_rep", 32'(key_repeat), 32'hf);
    chk("rst_any", 32'(any_press), 32'h1);
    tick(1);
    chk("rst_press_1c", 32'(key_press), 32'h0);

    key_n_in = 4'b1111;
    tick(6);
    chk("rel_all", 32'(key_release), 32'hf);
    chk("rel_lvl", 32'(key_level), 32'h0);
    tick(1);
    chk("rel_all_1c", 32'(key_release), 32'h0);
    tick(4);

    // bounce on key 0: never stable for 4 cycles
    for (int r = 0; r < 5; r++) begin
      key_n_in[0] = 1'b0;
      for (int c = 0; c < 3; c++) begin
        tick(1);
        chk("bounce", 32'({key_level[0], key_press[0], key_repeat[0]}), 32'h0);
      end
      key_n_in[0] = 1'b1;
      for (int c = 0; c < 3; c++) begin
        tick(1);
        chk("bounce", 32'({key_level[0], key_press[0], key_repeat[0]}), 32'h0);
      end
    end
    tick(4);
    chk("bounce_end", 32'(key_level), 32'h0);

    // clean press on masked key 2
    key_n_in[2] = 1'b0;
    tick(5);
    chk("k2_lvl_e5", 32'(key_level[2]), 32'h0);
    tick(1);
    chk("k2_lvl", 32'(key_level), 32'h4);
    chk("k2_press", 32'(key_press), 32'h4);
    chk("k2_rep", 32'(key_repeat), 32'h4);
    for (int c = 1; c <= 100; c++) begin
      tick(1);
      chk("k2_hold", 32'({key_press[2], key_repeat[2]}), 32'h0);
    end
    key_n_in[2] = 1'b1;
    tick(6);
    chk("k2_rel", 32'(key_release), 32'h4);
    tick(4);

    // auto-repeat on key 1; release acceptance lands on a terminal
    key_n_in[1] = 1'b0;
    tick(6);
    chk("k1_press", 32'(key_press), 32'h2);
    chk("k1_rep0", 32'(key_repeat), 32'h2);
    for (int c = 1; c <= 46; c++) begin
      if (c == 41) key_n_in[1] = 1'b1;
      tick(1);
      if (c == 46) begin
        chk("k1_rel", 32'(key_release), 32'h2);
        chk("k1_rel_norep", 32'(key_repeat), 32'h0);
      end else begin
        chk("k1_rep",
            32'(key_repeat),
            (c >= 10 && (c - 10) % 3 == 0) ? 32'h2 : 32'h0);
      end
    end
    for (int c = 0; c < 20; c++) begin
      tick(1);
      chk("k1_idle", 32'({key_repeat[1], key_release[1]}), 32'h0);
    end

    // simultaneous press of keys 0 and 3
    key_n_in = 4'b0110;
    tick(6);
    chk("sim_press", 32'(key_press), 32'h9);
    chk("sim_any", 32'(any_press), 32'h1);
    chk("sim_rep", 32'(key_repeat), 32'h9);
    tick(1);
    chk("sim_press_1c", 32'({key_press, any_press}), 32'h0);
    tick(12);
    chk("sim_k0_rep13", 32'(key_repeat), 32'h1);

    // asynchronous reset mid-repeat
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst", 32'(outs()), 32'h0);
    tick(2);
    chk("rst_hold", 32'(outs()), 32'h0);
    rst = 1'b1;
    tick(5);
    chk("rearm_e5", 32'(key_level), 32'h0);
    tick(1);
    chk("rearm_lvl", 32'(key_level), 32'h9);
    chk("rearm_press", 32'(key_press), 32'h9);
    chk("rearm_rep", 32'(key_repeat), 32'h9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
